// File: rtl/saturn_pkg.sv
// rtl/saturn_pkg.sv - shared bus command codes, program-entry layout and phase constants
//
// Purpose : common definitions for the Saturn control unit and its helpers.
// Contents: 4-bit bus command code space, 5-bit program-entry struct
//           (bit4 = command flag), one-hot phase strobes, start-up
//           sequencer states and the start-up program lookup.

package saturn_pkg;

  typedef enum logic [3:0] {
    CMD_PC_READ    = 4'h0,
    CMD_PC_WRITE   = 4'h1,
    CMD_DP_READ    = 4'h2,
    CMD_DP_WRITE   = 4'h3,
    CMD_LOAD_PC    = 4'h4,
    CMD_LOAD_DP    = 4'h5,
    CMD_CONFIG     = 4'h6,
    CMD_UNCONFIG   = 4'h7,
    CMD_POLL       = 4'h8,
    CMD_RSVD_9     = 4'h9,
    CMD_BUS_RESET  = 4'hA,
    CMD_RSVD_B     = 4'hB,
    CMD_RSVD_C     = 4'hC,
    CMD_RSVD_D     = 4'hD,
    CMD_RSVD_E     = 4'hE,
    CMD_SHUTDOWN   = 4'hF
  } bus_cmd_t;

  localparam int ENTRY_CMD_BIT = 4;

  // is_cmd lands on bit ENTRY_CMD_BIT; code is either a command or a data nibble
  typedef struct packed {
    logic       is_cmd;
    logic [3:0] code;
  } prog_entry_t;

  localparam logic [3:0] PHASE_0 = 4'b0001;
  localparam logic [3:0] PHASE_1 = 4'b0010;
  localparam logic [3:0] PHASE_2 = 4'b0100;
  localparam logic [3:0] PHASE_3 = 4'b1000;

  // Encoding doubles as the start-up program index (0..6), SEQ_DONE = 7
  typedef enum logic [2:0] {
    SEQ_LOAD_PC = 3'd0,
    SEQ_NIB0    = 3'd1,
    SEQ_NIB1    = 3'd2,
    SEQ_NIB2    = 3'd3,
    SEQ_NIB3    = 3'd4,
    SEQ_NIB4    = 3'd5,
    SEQ_PC_READ = 3'd6,
    SEQ_DONE    = 3'd7
  } seq_state_t;

  // Start-up program: LOAD_PC, vector nibbles LSB first, PC_READ
  function automatic prog_entry_t startup_entry(input seq_state_t s, input logic [19:0] vec);
    prog_entry_t e;
    e.is_cmd = 1'b0;
    e.code   = 4'h0;
    case (s)
      SEQ_LOAD_PC: begin e.is_cmd = 1'b1; e.code = CMD_LOAD_PC; end
      SEQ_NIB0:    e.code = vec[3:0];
      SEQ_NIB1:    e.code = vec[7:4];
      SEQ_NIB2:    e.code = vec[11:8];
      SEQ_NIB3:    e.code = vec[15:12];
      SEQ_NIB4:    e.code = vec[19:16];
      SEQ_PC_READ: begin e.is_cmd = 1'b1; e.code = CMD_PC_READ; end
      default:     ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/saturn_ctrl_unit_if.sv
// rtl/saturn_ctrl_unit_if.sv - phase inputs and program-ring outputs of the control unit
//
// Purpose : bundles the bus-phase inputs and program-ring outputs.
// Signals : i_phases (4, one-hot strobe), i_phase (2, binary index),
//           i_cycle_ctr (32, trace only), o_debug_cycle (1),
//           o_program_address (5), o_program_data (5), o_error (1).
// Modports: master drives phases/counter, slave is the control unit.

interface saturn_ctrl_unit_if;
  logic [3:0]  i_phases;
  logic [1:0]  i_phase;
  logic [31:0] i_cycle_ctr;
  logic        o_debug_cycle;
  logic [4:0]  o_program_address;
  logic [4:0]  o_program_data;
  logic        o_error;

  modport master (
    output i_phases, i_phase, i_cycle_ctr,
    input  o_debug_cycle, o_program_address, o_program_data, o_error
  );

  modport slave (
    input  i_phases, i_phase, i_cycle_ctr,
    output o_debug_cycle, o_program_address, o_program_data, o_error
  );
endinterface

// File: rtl/saturn_debug_gen.sv
// rtl/saturn_debug_gen.sv - periodic debug-cycle generator
//
// Purpose : marks the last bus cycle of every DEBUG_INTERVAL-cycle period.
// Ports   : clk, reset (sync, active-high), i_phases (4, one-hot),
//           o_debug_cycle (1, high for all phases of a debug cycle).

module saturn_debug_gen
  import saturn_pkg::*;
#(
  parameter int DEBUG_INTERVAL = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_phases,
  output logic       o_debug_cycle
);

  localparam int            CW   = $clog2(DEBUG_INTERVAL);
  localparam logic [CW-1:0] LAST = CW'(DEBUG_INTERVAL - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  assign cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);

  // Advancing on the phase-3 edge makes the flag cover the whole next bus cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      o_debug_cycle <= 1'b0;
    end else if (i_phases == PHASE_3) begin
      cnt           <= cnt_next;
      o_debug_cycle <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/saturn_ctrl_unit.sv
// rtl/saturn_ctrl_unit.sv - Saturn master sequencer: start-up program ring fill
//
// Purpose : after reset, writes LOAD_PC, five reset-vector nibbles and
//           PC_READ into the bus controller's 32-entry ring, one entry per
//           non-debug bus cycle; flags inconsistent phase inputs.
// Ports   : i_clk, i_reset (sync, active-high),
//           bus (saturn_ctrl_unit_if.slave).

module saturn_ctrl_unit
  import saturn_pkg::*;
#(
  parameter logic [19:0] RESET_VECTOR   = 20'h00000,
  parameter int          DEBUG_INTERVAL = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  saturn_ctrl_unit_if.slave     bus
);

  seq_state_t  seq_q, seq_d;
  logic [4:0]  addr_q, addr_d;
  prog_entry_t data_q, data_d;
  logic        err_q, err_d;
  logic        debug_cycle;
  logic        phase_illegal;
  logic        push;
  logic        cycle_ctr_unused;

  // Cycle counter is a trace aid only
  assign cycle_ctr_unused = ^bus.i_cycle_ctr;

  saturn_debug_gen #(
    .DEBUG_INTERVAL(DEBUG_INTERVAL)
  ) u_debug_gen (
    .clk          (i_clk),
    .reset        (i_reset),
    .i_phases     (bus.i_phases),
    .o_debug_cycle(debug_cycle)
  );

  // Equality against the decoded index also rejects zero and multi-hot strobes
  assign phase_illegal = (bus.i_phases != (4'b0001 << bus.i_phase));

  assign push = (bus.i_phases == PHASE_0) && !debug_cycle && !err_q && (seq_q != SEQ_DONE);

  always_comb begin
    seq_d  = seq_q;
    addr_d = addr_q;
    data_d = data_q;
    err_d  = err_q | phase_illegal;
    if (push) begin
      addr_d = addr_q + 5'd1;   // 31 -> 0 wrap is the natural 5-bit overflow
      data_d = startup_entry(seq_q, RESET_VECTOR);
      seq_d  = seq_state_t'(seq_q + 3'd1);
    end
  end

  // Pointer 31 means "ring empty" to the consumer, whose read pointer also resets to 31
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      seq_q  <= SEQ_LOAD_PC;
      addr_q <= 5'd31;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign bus.o_debug_cycle     = debug_cycle;
  assign bus.o_program_address = addr_q;
  assign bus.o_program_data    = data_q;
  assign bus.o_error           = err_q;

endmodule

// File: tb/tb_saturn_ctrl_unit.sv
// tb/tb_saturn_ctrl_unit.sv - directed bench for saturn_ctrl_unit (two parameter sets)

module tb_saturn_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  phases;
  logic [1:0]  phase;
  logic [31:0] cyc;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 32'd0 : cyc + 32'd1;

  saturn_ctrl_unit_if if_a ();
  saturn_ctrl_unit_if if_b ();

  assign if_a.i_phases    = phases;
  assign if_a.i_phase     = phase;
  assign if_a.i_cycle_ctr = cyc;
  assign if_b.i_phases    = phases;
  assign if_b.i_phase     = phase;
  assign if_b.i_cycle_ctr = cyc;

  saturn_ctrl_unit #(.RESET_VECTOR(20'h00000), .DEBUG_INTERVAL(4)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(if_a.slave)
  );

  saturn_ctrl_unit #(.RESET_VECTOR(20'h12345), .DEBUG_INTERVAL(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(if_b.slave)
  );

  int total = 0;
  int bad   = 0;

  // Per-bus-cycle expectations after the phase-0 edge of cycle c
  int exp_addr_a [13] = '{0, 1, 2, 2, 3, 4, 5, 5, 6, 6, 6, 6, 6};
  int exp_data_a [13] = '{'h14, 0, 0, 0, 0, 0, 0, 0, 'h10, 'h10, 'h10, 'h10, 'h10};
  int exp_dbg_a  [13] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
  int exp_addr_b [13] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6};
  int exp_data_b [13] = '{'h14, 'h14, 'h05, 'h05, 'h04, 'h04, 'h03, 'h03, 'h02, 'h02, 'h01, 'h01, 'h10};
  int exp_dbg_b  [13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] ph, input logic [1:0] idx);
    @(negedge clk);
    rst    = r;
    phases = ph;
    phase  = idx;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle();
    for (int p = 0; p < 4; p++) step(1'b0, 4'(4'b0001 << p), 2'(p));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " addr_a"}, 32'(if_a.o_program_address), 32'd31);
    check({tag, " data_a"}, 32'(if_a.o_program_data), 32'd0);
    check({tag, " dbg_a"},  32'(if_a.o_debug_cycle), 32'd0);
    check({tag, " err_a"},  32'(if_a.o_error), 32'd0);
    check({tag, " addr_b"}, 32'(if_b.o_program_address), 32'd31);
    check({tag, " data_b"}, 32'(if_b.o_program_data), 32'd0);
    check({tag, " dbg_b"},  32'(if_b.o_debug_cycle), 32'd0);
    check({tag, " err_b"},  32'(if_b.o_error), 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    phases = 4'b0001;
    phase  = 2'd0;

    // Reset and full start-up program on both parameter sets
    step(1'b1, 4'b0001, 2'd0);
    step(1'b1, 4'b0001, 2'd0);
    check_reset_state("rst0");

    for (int c = 0; c < 13; c++) begin
      for (int p = 0; p < 4; p++) begin
        // debug flag in force for the edge about to carry phase p of cycle c
        check($sformatf("dbg_a c%0d p%0d", c, p), 32'(if_a.o_debug_cycle), 32'(exp_dbg_a[c]));
        check($sformatf("dbg_b c%0d p%0d", c, p), 32'(if_b.o_debug_cycle), 32'(exp_dbg_b[c]));
        step(1'b0, 4'(4'b0001 << p), 2'(p));
        check($sformatf("addr_a c%0d p%0d", c, p), 32'(if_a.o_program_address), 32'(exp_addr_a[c]));
        check($sformatf("data_a c%0d p%0d", c, p), 32'(if_a.o_program_data), 32'(exp_data_a[c]));
        check($sformatf("addr_b c%0d p%0d", c, p), 32'(if_b.o_program_address), 32'(exp_addr_b[c]));
        check($sformatf("data_b c%0d p%0d", c, p), 32'(if_b.o_program_data), 32'(exp_data_b[c]));
      end
    end
    check("err_a after run", 32'(if_a.o_error), 32'd0);

    // Multi-hot strobe mid-sequence: sticky error, pointer frozen
    step(1'b1, 4'b0001, 2'd0);
    run_cycle();
    check("pre err addr_a", 32'(if_a.o_program_address), 32'd0);
    step(1'b0, 4'b0011, 2'd0);
    check("err set a", 32'(if_a.o_error), 32'd1);
    check("err set b", 32'(if_b.o_error), 32'd1);
    run_cycle();
    run_cycle();
    check("err sticky a", 32'(if_a.o_error), 32'd1);
    check("err sticky b", 32'(if_b.o_error), 32'd1);
    check("err frozen addr_a", 32'(if_a.o_program_address), 32'd0);
    check("err frozen addr_b", 32'(if_b.o_program_address), 32'd0);
    check("err frozen data_a", 32'(if_a.o_program_data), 32'h14);
    step(1'b1, 4'b0001, 2'd0);
    check_reset_state("err clr");

    // One-hot strobe disagreeing with the binary index
    step(1'b0, 4'b0010, 2'd2);
    check("idx err a", 32'(if_a.o_error), 32'd1);
    check("idx err b", 32'(if_b.o_error), 32'd1);
    step(1'b1, 4'b0001, 2'd0);
    check_reset_state("idx clr");

    // Reset after three pushes restarts the program
    run_cycle();
    run_cycle();
    run_cycle();
    check("mid addr_a", 32'(if_a.o_program_address), 32'd2);
    check("mid data_a", 32'(if_a.o_program_data), 32'h00);
    check("mid dbg_a", 32'(if_a.o_debug_cycle), 32'd1);
    check("mid addr_b", 32'(if_b.o_program_address), 32'd1);
    check("mid dbg_b", 32'(if_b.o_debug_cycle), 32'd1);
    step(1'b1, 4'b0001, 2'd0);
    check_reset_state("mid rst");
    step(1'b0, 4'b0001, 2'd0);
    check("restart addr_a", 32'(if_a.o_program_address), 32'd0);
    check("restart data_a", 32'(if_a.o_program_data), 32'h14);
    check("restart addr_b", 32'(if_b.o_program_address), 32'd0);
    check("restart data_b", 32'(if_b.o_program_data), 32'h14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
